boot_controller: RTL and testbench

Boot sequencer for the instruction-fetch path: holds the core in reset, releases it to execute from BIOS, detects the BIOS HALT instruction, then copies a fixed-size program image from the BIOS ROM into instruction memory through a ready/valid write port. After the copy it switches the instruction-source select to memory and applies a second core reset before entering RUN. It drives the BIOS/memory instruction mux select and the core reset. It sits between the BIOS ROM, the instruction memory write port and the core.

---
 rtl/boot_controller.sv | 160 ++++++++++++++++
 tb/tb_boot_controller.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_controller.sv
// Boot sequencer: holds the core in reset, runs the BIOS until HALT, copies the
// program image from BIOS ROM into instruction memory, then restarts the core on memory.
module boot_controller #(
    parameter int         DATA_WIDTH  = 32,
    parameter int         ADDR_WIDTH  = 10,
    parameter int         IMAGE_WORDS = 256,
    parameter int         SRC_BASE    = 0,
    parameter int         RST_CYCLES  = 4,
    parameter logic [5:0] HALT_OPCODE = 6'b011101
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] bios_instr,
    input  logic                  reboot,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ready,
    output logic                  sel_memory,
    output logic                  cpu_rst,
    output logic                  boot_done,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_BIOS       = 3'd1,
        S_COPY_READ  = 3'd2,
        S_COPY_LATCH = 3'd3,
        S_COPY_WRITE = 3'd4,
        S_CPU_RST    = 3'd5,
        S_RUN        = 3'd6
    } state_t;

    localparam int                    HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int                    K_W       = ADDR_WIDTH + 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [K_W-1:0]        K_LAST    = K_W'(IMAGE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(SRC_BASE);

    state_t                r_state;
    logic [HOLD_W-1:0]     r_hold;
    logic [K_W-1:0]        r_k;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_en;
    logic                  r_cpu_rst;
    logic                  r_sel_memory;
    logic                  r_boot_done;

    logic                  w_halt;
    logic [K_W-1:0]        w_k_next;
    logic                  w_unused_instr_bits;

    assign w_halt              = (bios_instr[31:26] == HALT_OPCODE);
    assign w_k_next            = r_k + 1'b1;
    assign w_unused_instr_bits = ^bios_instr[25:0];

    // NOTE: all state lives in one clocked block with non-blocking assignments,
    // so every output below is a flop (or a slice of one) and never sees an input directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RESET_HOLD;
            r_hold       <= '0;
            r_k          <= '0;
            r_src_addr   <= BASE;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_sel_memory <= 1'b0;
            r_boot_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RESET_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_hold    <= '0;
                        r_cpu_rst <= 1'b0;
                        r_state   <= S_BIOS;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_BIOS: begin
                    if (w_halt) begin
                        r_k        <= '0;
                        r_src_addr <= BASE;
                        r_cpu_rst  <= 1'b1;
                        r_state    <= S_COPY_READ;
                    end
                end
                S_COPY_READ: begin
                    r_state <= S_COPY_LATCH;
                end
                S_COPY_LATCH: begin
                    // ROM data answers the address presented during COPY_READ.
                    r_wr_data <= src_data;
                    r_wr_en   <= 1'b1;
                    r_state   <= S_COPY_WRITE;
                end
                S_COPY_WRITE: begin
                    if (mem_wr_ready) begin
                        r_wr_en <= 1'b0;
                        if (r_k == K_LAST) begin
                            r_hold       <= '0;
                            r_sel_memory <= 1'b1;
                            r_state      <= S_CPU_RST;
                        end else begin
                            r_k        <= w_k_next;
                            r_src_addr <= BASE + w_k_next[ADDR_WIDTH-1:0];
                            r_state    <= S_COPY_READ;
                        end
                    end
                end
                S_CPU_RST: begin
                    if (r_hold == HOLD_LAST) begin
                        r_hold      <= '0;
                        r_cpu_rst   <= 1'b0;
                        r_boot_done <= 1'b1;
                        r_state     <= S_RUN;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
                S_RUN: begin
                    if (reboot) begin
                        r_hold       <= '0;
                        r_k          <= '0;
                        r_cpu_rst    <= 1'b1;
                        r_sel_memory <= 1'b0;
                        r_boot_done  <= 1'b0;
                        r_state      <= S_RESET_HOLD;
                    end
                end
                default: begin
                    r_state      <= S_RESET_HOLD;
                    r_hold       <= '0;
                    r_k          <= '0;
                    r_src_addr   <= BASE;
                    r_wr_data    <= '0;
                    r_wr_en      <= 1'b0;
                    r_cpu_rst    <= 1'b1;
                    r_sel_memory <= 1'b0;
                    r_boot_done  <= 1'b0;
                end
            endcase
        end
    end

    assign state       = r_state;
    assign src_addr    = r_src_addr;
    assign mem_wr_en   = r_wr_en;
    assign mem_wr_addr = r_k[ADDR_WIDTH-1:0];
    assign mem_wr_data = r_wr_data;
    assign sel_memory  = r_sel_memory;
    assign cpu_rst     = r_cpu_rst;
    assign boot_done   = r_boot_done;

endmodule

// File: tb/tb_boot_controller.sv
// Self-checking bench for boot_controller: expected image writes are queued when
// HALT is issued and compared as the memory port accepts each write.
module tb_boot_controller;

    localparam int DW       = 32;
    localparam int AW       = 10;
    localparam int IW       = 4;
    localparam int SRC_BASE = 0;
    localparam int RC       = 4;

    localparam logic [2:0] S_RESET_HOLD = 3'd0;
    localparam logic [2:0] S_BIOS       = 3'd1;
    localparam logic [2:0] S_COPY_READ  = 3'd2;
    localparam logic [2:0] S_COPY_LATCH = 3'd3;
    localparam logic [2:0] S_COPY_WRITE = 3'd4;
    localparam logic [2:0] S_CPU_RST    = 3'd5;
    localparam logic [2:0] S_RUN        = 3'd6;

    localparam logic [DW-1:0] HALT_WORD = 32'h7400_0000;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] bios_instr;
    logic          reboot;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_ready;
    logic          sel_memory;
    logic          cpu_rst;
    logic          boot_done;
    logic [2:0]    state;

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    wr_t exp_e;

    boot_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .IMAGE_WORDS(IW),
        .SRC_BASE   (SRC_BASE),
        .RST_CYCLES (RC),
        .HALT_OPCODE(6'b011101)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bios_instr  (bios_instr),
        .reboot      (reboot),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_wr_ready(mem_wr_ready),
        .sel_memory  (sel_memory),
        .cpu_rst     (cpu_rst),
        .boot_done   (boot_done),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Synchronous BIOS ROM: word i of the image holds 0xA0 + i.
    always @(posedge clk) src_data <= DW'(32'hA0) + DW'(src_addr - AW'(SRC_BASE));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int n = 0;
        while (state != s && n < budget) begin
            tick;
            n++;
        end
        check(tag, state, s);
    endtask

    task automatic push_image;
        for (int i = 0; i < IW; i++) begin
            exp_q.push_back('{addr: AW'(i), data: DW'(32'hA0 + i)});
        end
    endtask

    // Scoreboard consumer: an accepted write must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && mem_wr_en && mem_wr_ready) begin
            check("sb_write_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_e = exp_q.pop_front();
                check("sb_addr", mem_wr_addr, exp_e.addr);
                check("sb_data", mem_wr_data, exp_e.data);
            end
        end
    end

    // Starts in BIOS; issues HALT and runs the copy until CPU_RST is reached.
    task automatic copy_image(input int stall, input bit poke_reboot);
        int cnt     = 0;
        bit stalled = 1'b0;
        push_image();
        bios_instr = HALT_WORD;
        tick;
        bios_instr = '0;
        check("halt_state", state, S_COPY_READ);
        check("halt_cpu_rst", cpu_rst, 1);
        check("halt_src_addr", src_addr, AW'(SRC_BASE));
        while (state != S_CPU_RST && cnt < 200) begin
            if (stall > 0 && !stalled && state == S_COPY_LATCH && mem_wr_addr == AW'(2)) begin
                stalled      = 1'b1;
                mem_wr_ready = 1'b0;
                tick;
                cnt++;
                for (int i = 0; i < stall; i++) begin
                    check("bp_wr_en", mem_wr_en, 1);
                    check("bp_wr_addr", mem_wr_addr, 2);
                    check("bp_wr_data", mem_wr_data, 32'hA2);
                    check("bp_state", state, S_COPY_WRITE);
                    tick;
                    cnt++;
                end
                mem_wr_ready = 1'b1;
            end else if (poke_reboot && state == S_COPY_WRITE && mem_wr_addr == AW'(1)) begin
                reboot = 1'b1;
                tick;
                cnt++;
                reboot = 1'b0;
                check("reboot_in_copy_ignored", state, S_COPY_READ);
            end else begin
                tick;
                cnt++;
            end
        end
        check("copy_cycles", cnt, 3 * IW + stall);
        check("sb_drained_after_copy", exp_q.size(), 0);
    endtask

    // Starts at the first CPU_RST cycle; optionally raises reboot as RUN is entered.
    task automatic cpu_rst_to_run(input bit reboot_at_entry);
        check("cpurst_sel_memory", sel_memory, 1);
        check("cpurst_cpu_rst", cpu_rst, 1);
        check("cpurst_boot_done", boot_done, 0);
        repeat (RC - 1) tick;
        check("cpurst_still_held", state, S_CPU_RST);
        reboot = reboot_at_entry;
        tick;
        check("run_state", state, S_RUN);
        check("run_boot_done", boot_done, 1);
        check("run_cpu_rst", cpu_rst, 0);
        check("run_sel_memory", sel_memory, 1);
        if (reboot_at_entry) begin
            tick;
            reboot = 1'b0;
            check("reboot_state", state, S_RESET_HOLD);
            check("reboot_sel_memory", sel_memory, 0);
            check("reboot_cpu_rst", cpu_rst, 1);
            check("reboot_boot_done", boot_done, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bios_instr   = '0;
        reboot       = 1'b0;
        mem_wr_ready = 1'b1;
        repeat (2) tick;
        check("rst_state", state, S_RESET_HOLD);
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_sel_memory", sel_memory, 0);
        check("rst_boot_done", boot_done, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_src_addr", src_addr, AW'(SRC_BASE));
        check("rst_wr_addr", mem_wr_addr, 0);
        check("rst_wr_data", mem_wr_data, 0);

        // Release: cpu_rst must stay high for exactly RC edges; HALT is ignored meanwhile.
        rst        = 1'b0;
        bios_instr = HALT_WORD;
        for (int i = 0; i < RC; i++) begin
            check("release_cpu_rst", cpu_rst, 1);
            check("release_state", state, S_RESET_HOLD);
            tick;
        end
        bios_instr = '0;
        check("bios_state", state, S_BIOS);
        check("bios_cpu_rst", cpu_rst, 0);
        check("bios_sel_memory", sel_memory, 0);

        // Plain copy, then HALT in RUN is ignored, then reboot from RUN.
        copy_image(0, 1'b0);
        cpu_rst_to_run(1'b0);
        bios_instr = HALT_WORD;
        repeat (2) tick;
        bios_instr = '0;
        check("halt_in_run_ignored", state, S_RUN);
        reboot = 1'b1;
        tick;
        reboot = 1'b0;
        check("reboot_run_state", state, S_RESET_HOLD);
        check("reboot_run_sel", sel_memory, 0);
        check("reboot_run_cpu_rst", cpu_rst, 1);
        wait_state(S_BIOS, 3 * RC, "reboot_back_to_bios");

        // Backpressure on word 2 with a reboot pulse mid-copy; reboot at RUN entry.
        copy_image(5, 1'b1);
        cpu_rst_to_run(1'b1);
        wait_state(S_BIOS, 3 * RC, "reboot_entry_back_to_bios");

        // Asynchronous reset while word 2 is pending on the write port.
        push_image();
        bios_instr = HALT_WORD;
        tick;
        bios_instr = '0;
        wait_state(S_COPY_LATCH, 3 * IW, "mid_copy_reach_latch");
        while (mem_wr_addr != AW'(2) && state != S_CPU_RST && n_checks < 10000) begin
            tick;
            if (state != S_COPY_LATCH) wait_state(S_COPY_LATCH, 8, "mid_copy_next_latch");
        end
        mem_wr_ready = 1'b0;
        tick;
        check("pre_rst_wr_en", mem_wr_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_wr_en", mem_wr_en, 0);
        check("async_rst_state", state, S_RESET_HOLD);
        check("async_rst_cpu_rst", cpu_rst, 1);
        check("async_rst_wr_addr", mem_wr_addr, 0);
        check("async_rst_wr_data", mem_wr_data, 0);
        check("async_rst_words_written", exp_q.size(), IW - 2);
        exp_q.delete();
        tick;
        rst          = 1'b0;
        mem_wr_ready = 1'b1;
        wait_state(S_BIOS, 3 * RC, "async_rst_back_to_bios");

        // Rerun restarts the image from word 0.
        copy_image(0, 1'b0);
        cpu_rst_to_run(1'b0);

        check("sb_final_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
